jtag_user_dr_tx: RTL

JTAG_USER_DR_TX -- requirements
Module: jtag_user_dr_tx

---
 rtl/jtag_user_dr_tx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/jtag_user_dr_tx.sv
// Transmit path from fabric to a JTAG host through JTAGG user register ER1.
// Words wait in a small FIFO and are read out as DR frames {data, valid_flag}.
module jtag_user_dr_tx #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                   jtck,
   input  logic                   jrstn,
   input  logic                   jce1,
   input  logic                   jshift,
   input  logic                   jupdate,
   input  logic                   jtdi,
   output logic                   jtdo1,
   input  logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int AW     = $clog2(DEPTH);
   localparam int LVL_W  = AW + 1;
   localparam int SR_W   = DATA_W + 1;
   localparam int BCNT_W = $clog2(DATA_W + 2);

   localparam logic [BCNT_W-1:0] FRAME_LEN = BCNT_W'(SR_W);
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

   logic              capture;
   logic              shift_en;
   logic              update;
   logic              push;
   logic              pop;
   logic              fifo_empty;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   logic [SR_W-1:0]   sr_q, sr_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              armed_q, armed_d;

   assign capture  = jce1 & ~jshift;
   assign shift_en = jce1 & jshift;
   assign update   = jupdate;

   assign fifo_empty = (level_q == '0);
   assign tx_ready   = (level_q != FULL_LVL);
   assign push       = tx_valid & tx_ready;

   // A word leaves the FIFO only after the host has clocked out the whole frame.
   assign pop = update & armed_q & (bcnt_q == FRAME_LEN);

   assign jtdo1      = sr_q[0];
   assign fifo_level = level_q;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      armed_d = armed_q;

      if (capture) begin
         sr_d    = fifo_empty ? '0 : {mem_q[rd_ptr_q], 1'b1};
         bcnt_d  = '0;
         armed_d = ~fifo_empty;
      end else if (shift_en) begin
         sr_d = {jtdi, sr_q[SR_W-1:1]};
         if (bcnt_q != FRAME_LEN) begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end

      if (update) begin
         armed_d = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Simultaneous push and pop leaves the level where it was.
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: the storage array is deliberately not reset; pointers and level decide which entries are live.
   always_ff @(posedge jtck) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge jtck or negedge jrstn) begin
      if (!jrstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         sr_q     <= '0;
         bcnt_q   <= '0;
         armed_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         sr_q     <= sr_d;
         bcnt_q   <= bcnt_d;
         armed_q  <= armed_d;
      end
   end

endmodule
